// File: rtl/vga_out_stage_pkg.sv
// Default 640x480@60 timing and the pixel/count types shared by the output stage
// and the layer generators that consume hpos/vpos.
package vga_out_stage_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Asserted level of hsync/vsync; 0 is standard active-low VGA.
  localparam logic SYNC_POL = 1'b0;

  localparam int CNT_W = 10;

  typedef logic [5:0]       rgb222_t;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic in_window(input int value, input int lo, input int len);
    return (value >= lo) && (value < lo + len);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Beam position counters with combinational sync and active-area decode.
module vga_sync_counter #(
  parameter int H_ACTIVE = vga_out_stage_pkg::H_ACTIVE,
  parameter int H_FP     = vga_out_stage_pkg::H_FP,
  parameter int H_SYNC   = vga_out_stage_pkg::H_SYNC,
  parameter int H_BP     = vga_out_stage_pkg::H_BP,
  parameter int V_ACTIVE = vga_out_stage_pkg::V_ACTIVE,
  parameter int V_FP     = vga_out_stage_pkg::V_FP,
  parameter int V_SYNC   = vga_out_stage_pkg::V_SYNC,
  parameter int V_BP     = vga_out_stage_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_c,
  output logic       vs_c,
  output logic       active
);
  import vga_out_stage_pkg::*;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

  logic h_wrap;
  logic v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // The vertical count only moves on the horizontal wrap, so the last pixel
  // of the frame wraps both counters on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign active = (h_cnt < cnt_t'(H_ACTIVE)) && (v_cnt < cnt_t'(V_ACTIVE));
  assign hs_c   = in_window(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
  assign vs_c   = in_window(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);

endmodule

// File: rtl/vga_out_stage.sv
// Final video stage: beam timing, blanking outside the active area, and a single
// output register so pixel and syncs leave the block on the same edge.
module vga_out_stage #(
  parameter int   H_ACTIVE = vga_out_stage_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_out_stage_pkg::H_FP,
  parameter int   H_SYNC   = vga_out_stage_pkg::H_SYNC,
  parameter int   H_BP     = vga_out_stage_pkg::H_BP,
  parameter int   V_ACTIVE = vga_out_stage_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_out_stage_pkg::V_FP,
  parameter int   V_SYNC   = vga_out_stage_pkg::V_SYNC,
  parameter int   V_BP     = vga_out_stage_pkg::V_BP,
  parameter logic SYNC_POL = vga_out_stage_pkg::SYNC_POL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  input  logic [5:0] pixel_in,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       active,
  output logic [5:0] rgb_out,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);
  import vga_out_stage_pkg::*;

  logic    hs_c;
  logic    vs_c;
  logic    at_origin;
  rgb222_t pix_blanked;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_ce (pix_ce),
    .h_cnt  (hpos),
    .v_cnt  (vpos),
    .hs_c   (hs_c),
    .vs_c   (vs_c),
    .active (active)
  );

  assign pix_blanked = active ? pixel_in : '0;
  assign at_origin   = (hpos == '0) && (vpos == '0);

  // frame_start is a single clk pulse even at reduced pixel rate, so it is
  // reloaded every clk while the video registers only move with pix_ce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_out     <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && at_origin;
      if (pix_ce) begin
        rgb_out <= pix_blanked;
        hsync   <= hs_c ? SYNC_POL : ~SYNC_POL;
        vsync   <= vs_c ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule
